// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity codes, FSM encoding, divisor floor.
package uart_pkg;

   localparam int unsigned MIN_DIV = 2;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Code 3 is an alias for "no parity".
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; full blocks pushes, empty blocks pops.
module sync_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_en, pop_en;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign level = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push_en  = push & ~full;
      pop_en   = pop & ~empty;
      if (push_en) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, runtime baud divisor, optional parity and 1/2 stop bits.
// Frame config is captured when a word is popped; TX is registered one cycle behind the FSM.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BW    = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FIFO_AW    = 3,
   parameter int unsigned BAUD_BIT   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_BW-1:0]  in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BAUD_BIT-1:0] baud_div,
   input  logic [1:0]          parity_mode,
   input  logic                two_stop,
   output logic                TX,
   output logic                busy,
   output logic                frame_done,
   output logic [FIFO_AW:0]    fifo_level
);

   localparam int unsigned BIT_CW = $clog2(DATA_BW);

   logic [2:0]          state_q, state_d;
   logic [DATA_BW-1:0]  shift_q, shift_d;
   logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BAUD_BIT-1:0] baud_cnt_q, baud_cnt_d;
   logic [BAUD_BIT-1:0] div_q, div_d;
   logic [1:0]          par_mode_q, par_mode_d;
   logic                two_stop_q, two_stop_d;
   logic                par_bit_q, par_bit_d;
   logic                stop_cnt_q, stop_cnt_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_BW-1:0]  fifo_rdata;
   logic                fifo_full, fifo_empty, fifo_push;
   logic                load, tick;
   logic [BAUD_BIT-1:0] div_clamp;

   assign in_ready   = rst & ~fifo_full;
   assign fifo_push  = in_valid & in_ready;
   assign TX         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   sync_fifo #(
      .DW    (DATA_BW),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (in_data),
      .pop   (load),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign div_clamp = (baud_div < BAUD_BIT'(MIN_DIV)) ? BAUD_BIT'(MIN_DIV) : baud_div;
   assign tick      = (baud_cnt_q == div_q - BAUD_BIT'(1));

   // Next-state, baud timing, shifter and registered-output decode.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      div_d      = div_q;
      par_mode_d = par_mode_q;
      two_stop_d = two_stop_q;
      par_bit_d  = par_bit_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;
      load       = 1'b0;
      baud_cnt_d = tick ? '0 : baud_cnt_q + BAUD_BIT'(1);

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            load       = ~fifo_empty;
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_CW'(DATA_BW - 1)) begin
                  state_d = par_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (two_stop_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  load    = ~fifo_empty;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Popping a word starts a frame and freezes its configuration.
      if (load) begin
         state_d    = ST_START;
         shift_d    = fifo_rdata;
         par_mode_d = parity_mode;
         two_stop_d = two_stop;
         div_d      = div_clamp;
         par_bit_d  = (parity_mode == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
         baud_cnt_d = '0;
      end

      case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
         ST_PARITY: tx_d = par_bit_q;
         default:   tx_d = 1'b1;
      endcase

      busy_d = (state_q != ST_IDLE) | ~fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         div_q      <= BAUD_BIT'(MIN_DIV);
         par_mode_q <= PAR_NONE;
         two_stop_q <= 1'b0;
         par_bit_q  <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         par_mode_q <= par_mode_d;
         two_stop_q <= two_stop_d;
         par_bit_q  <= par_bit_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule
